// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means APB register slice: register map, status bits, FSM states
package kmeans_pkg;

    // Bit positions inside the status register
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    // APB register indices (paddr values)
    typedef enum logic [3:0] {
        REG_STATUS   = 4'd0,
        REG_GO       = 4'd1,
        REG_CENT1    = 4'd2,
        REG_CENT2    = 4'd3,
        REG_CENT3    = 4'd4,
        REG_CENT4    = 4'd5,
        REG_CENT5    = 4'd6,
        REG_CENT6    = 4'd7,
        REG_CENT7    = 4'd8,
        REG_CENT8    = 4'd9,
        REG_RAM_ADDR = 4'd10,
        REG_RAM_DATA = 4'd11,
        REG_FIRST    = 4'd12,
        REG_LAST     = 4'd13
    } reg_idx_t;

    // APB transfer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_RAM_WAIT = 2'd2
    } apb_state_t;

endpackage

// File: rtl/kmeans_ram_window.sv
// Host window onto the split data RAM: address register, 91<->2x50-bit split/merge, access strobes
module kmeans_ram_window
    import kmeans_pkg::*;
#(
    parameter int addrWidth    = 9,
    parameter int dataWidth    = 91,
    parameter int ram_word_len = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    access,
    input  logic                    pwrite,
    input  logic                    sel_addr,
    input  logic                    sel_data,
    input  logic                    busy,
    input  logic [dataWidth-1:0]    pwdata,
    output logic [addrWidth-1:0]    ram_addr,
    output logic                    ram_we,
    output logic                    ram_re,
    output logic [ram_word_len-1:0] ram_wdata_lo,
    output logic [ram_word_len-1:0] ram_wdata_hi,
    input  logic [ram_word_len-1:0] ram_rdata_lo,
    input  logic [ram_word_len-1:0] ram_rdata_hi,
    output logic [dataWidth-1:0]    rdata
);

    localparam int HiBits  = dataWidth - ram_word_len;
    localparam int PadBits = 2 * ram_word_len - dataWidth;

    logic unused_rdata_pad;

    // RAM address register; frozen while the core owns the RAM, never auto-increments
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
        end else if (access && pwrite && sel_addr && !busy) begin
            ram_addr <= pwdata[addrWidth-1:0];
        end
    end

    // Strobes only fire in the APB access cycle and never while the core is running
    assign ram_we = access && pwrite && sel_data && !busy;
    assign ram_re = access && !pwrite && sel_data && !busy;

    // Split a data point across both RAM halves, zero-padding the top of the high half
    assign ram_wdata_lo = pwdata[ram_word_len-1:0];
    assign ram_wdata_hi = {{PadBits{1'b0}}, pwdata[dataWidth-1:ram_word_len]};

    // Merge the halves back; the padding bits of the high half carry no data
    assign rdata            = {ram_rdata_hi[HiBits-1:0], ram_rdata_lo};
    assign unused_rdata_pad = ^ram_rdata_hi[ram_word_len-1:HiBits];

endmodule

// File: rtl/kmeans_apb_slave.sv
// APB responder and register file for the k-means accelerator
module kmeans_apb_slave
    import kmeans_pkg::*;
#(
    parameter int addrWidth     = 9,
    parameter int dataWidth     = 91,
    parameter int ram_word_len  = 50,
    parameter int centroid_num  = 8,
    parameter int log2_cent_num = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [addrWidth-1:0]              paddr,
    input  logic                              pwrite,
    input  logic                              psel,
    input  logic                              penable,
    input  logic [dataWidth-1:0]              pwdata,
    output logic [dataWidth-1:0]              prdata,
    output logic                              pready,
    output logic                              interupt,
    output logic                              core_start,
    output logic                              core_busy_o,
    output logic [centroid_num*dataWidth-1:0] cent_flat,
    output logic [addrWidth-1:0]              first_addr,
    output logic [addrWidth-1:0]              last_addr,
    input  logic                              core_done,
    input  logic                              core_cent_we,
    input  logic [log2_cent_num-1:0]          core_cent_idx,
    input  logic [dataWidth-1:0]              core_cent_data,
    output logic [addrWidth-1:0]              ram_addr,
    output logic                              ram_we,
    output logic                              ram_re,
    output logic [ram_word_len-1:0]           ram_wdata_lo,
    output logic [ram_word_len-1:0]           ram_wdata_hi,
    input  logic [ram_word_len-1:0]           ram_rdata_lo,
    input  logic [ram_word_len-1:0]           ram_rdata_hi
);

    apb_state_t               state;
    logic [dataWidth-1:0]     cent [centroid_num];
    logic                     busy;
    logic                     done;
    logic                     access;
    logic                     wr_en;
    logic                     sel_status;
    logic                     sel_go;
    logic                     sel_cent;
    logic                     sel_ram_addr;
    logic                     sel_ram_data;
    logic                     sel_first;
    logic                     sel_last;
    logic [log2_cent_num-1:0] cent_sel;
    logic [dataWidth-1:0]     ram_merged;
    logic [dataWidth-1:0]     reg_rdata;

    assign sel_status   = (paddr == addrWidth'(REG_STATUS));
    assign sel_go       = (paddr == addrWidth'(REG_GO));
    assign sel_cent     = (paddr >= addrWidth'(REG_CENT1)) && (paddr <= addrWidth'(REG_CENT8));
    assign sel_ram_addr = (paddr == addrWidth'(REG_RAM_ADDR));
    assign sel_ram_data = (paddr == addrWidth'(REG_RAM_DATA));
    assign sel_first    = (paddr == addrWidth'(REG_FIRST));
    assign sel_last     = (paddr == addrWidth'(REG_LAST));
    assign cent_sel     = log2_cent_num'(paddr - addrWidth'(REG_CENT1));

    assign access      = (state == ST_ACCESS) && psel && penable;
    assign wr_en       = access && pwrite;
    assign pready      = (access && !ram_re) || ((state == ST_RAM_WAIT) && psel);
    assign core_busy_o = busy;

    kmeans_ram_window #(
        .addrWidth    (addrWidth),
        .dataWidth    (dataWidth),
        .ram_word_len (ram_word_len)
    ) u_ram_window (
        .clk          (clk),
        .rst_n        (rst_n),
        .access       (access),
        .pwrite       (pwrite),
        .sel_addr     (sel_ram_addr),
        .sel_data     (sel_ram_data),
        .busy         (busy),
        .pwdata       (pwdata),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_re       (ram_re),
        .ram_wdata_lo (ram_wdata_lo),
        .ram_wdata_hi (ram_wdata_hi),
        .ram_rdata_lo (ram_rdata_lo),
        .ram_rdata_hi (ram_rdata_hi),
        .rdata        (ram_merged)
    );

    // APB transfer FSM; a RAM read inserts exactly one wait state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (psel && !penable) state <= ST_ACCESS;
                ST_ACCESS: begin
                    if (!psel)        state <= ST_IDLE;
                    else if (penable) state <= ram_re ? ST_RAM_WAIT : ST_IDLE;
                end
                ST_RAM_WAIT: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Core control: go launches the core, core_done completes it; a completion beats a status clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            interupt   <= 1'b0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            if (core_done) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                interupt <= 1'b1;
            end else if (wr_en && sel_status) begin
                done     <= 1'b0;
                interupt <= 1'b0;
            end
            if (wr_en && sel_go && pwdata[0] && !busy) begin
                core_start <= 1'b1;
                busy       <= 1'b1;
                interupt   <= 1'b0;
            end
        end
    end

    // Valid RAM address range, locked while the core is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_addr <= '0;
            last_addr  <= '0;
        end else if (wr_en && !busy) begin
            if (sel_first) first_addr <= pwdata[addrWidth-1:0];
            if (sel_last)  last_addr  <= pwdata[addrWidth-1:0];
        end
    end

    // Centroid registers; core write-back is applied last so it wins over a host write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < centroid_num; i++) cent[i] <= '0;
        end else begin
            if (wr_en && sel_cent && !busy) cent[cent_sel] <= pwdata;
            if (core_cent_we) cent[core_cent_idx] <= core_cent_data;
        end
    end

    // Flatten centroids for the core, centroid 1 in the least significant slot
    always_comb begin
        cent_flat = '0;
        for (int i = 0; i < centroid_num; i++) cent_flat[i*dataWidth +: dataWidth] = cent[i];
    end

    // Read value of the addressed non-RAM register; unmapped and go read as zero
    always_comb begin
        reg_rdata = '0;
        if (sel_status) begin
            reg_rdata[STATUS_BUSY] = busy;
            reg_rdata[STATUS_DONE] = done;
        end else if (sel_cent) begin
            reg_rdata = cent[cent_sel];
        end else if (sel_ram_addr) begin
            reg_rdata[addrWidth-1:0] = ram_addr;
        end else if (sel_first) begin
            reg_rdata[addrWidth-1:0] = first_addr;
        end else if (sel_last) begin
            reg_rdata[addrWidth-1:0] = last_addr;
        end
    end

    // Read data is only driven while the transfer completes
    always_comb begin
        prdata = '0;
        if ((state == ST_RAM_WAIT) && psel) prdata = ram_merged;
        else if (pready)                    prdata = reg_rdata;
    end

endmodule

// File: tb/tb_kmeans_apb_slave.sv
// Self-checking bench for kmeans_apb_slave with a behavioural register-map model
module tb_kmeans_apb_slave;

    localparam int AW  = 9;
    localparam int DW  = 91;
    localparam int RW  = 50;
    localparam int CN  = 8;
    localparam int CIW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              interupt;
    logic              core_start;
    logic              core_busy_o;
    logic [CN*DW-1:0]  cent_flat;
    logic [AW-1:0]     first_addr;
    logic [AW-1:0]     last_addr;
    logic              core_done;
    logic              core_cent_we;
    logic [CIW-1:0]    core_cent_idx;
    logic [DW-1:0]     core_cent_data;
    logic [AW-1:0]     ram_addr;
    logic              ram_we;
    logic              ram_re;
    logic [RW-1:0]     ram_wdata_lo;
    logic [RW-1:0]     ram_wdata_hi;
    logic [RW-1:0]     ram_rdata_lo;
    logic [RW-1:0]     ram_rdata_hi;

    kmeans_apb_slave #(
        .addrWidth(AW), .dataWidth(DW), .ram_word_len(RW), .centroid_num(CN), .log2_cent_num(CIW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .interupt(interupt),
        .core_start(core_start), .core_busy_o(core_busy_o), .cent_flat(cent_flat),
        .first_addr(first_addr), .last_addr(last_addr), .core_done(core_done),
        .core_cent_we(core_cent_we), .core_cent_idx(core_cent_idx), .core_cent_data(core_cent_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re), .ram_wdata_lo(ram_wdata_lo),
        .ram_wdata_hi(ram_wdata_hi), .ram_rdata_lo(ram_rdata_lo), .ram_rdata_hi(ram_rdata_hi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int we_count = 0;
    int re_count = 0;
    int start_count = 0;

    // Count strobe cycles, sampled mid-cycle away from the active edge
    always @(negedge clk) begin
        #2;
        if (ram_we === 1'b1) we_count++;
        if (ram_re === 1'b1) re_count++;
        if (core_start === 1'b1) start_count++;
    end

    // Synchronous data RAM stand-in; junk in the padding bits must never reach prdata
    logic [DW-1:0] bram [int];
    always @(posedge clk) begin
        if (ram_we === 1'b1) bram[int'(ram_addr)] = {ram_wdata_hi[DW-RW-1:0], ram_wdata_lo};
        if (ram_re === 1'b1) begin
            logic [DW-1:0] w;
            w = bram.exists(int'(ram_addr)) ? bram[int'(ram_addr)] : '0;
            ram_rdata_lo <= w[RW-1:0];
            ram_rdata_hi <= {9'($urandom), w[DW-1:RW]};
        end
    end

    // Reference model of the register map
    logic [DW-1:0] m_cent [CN];
    logic [DW-1:0] m_ram [int];
    logic [AW-1:0] m_ramaddr, m_first, m_last;
    logic          m_busy, m_done, m_irq;
    int            m_starts;

    task automatic model_reset();
        for (int i = 0; i < CN; i++) m_cent[i] = '0;
        m_ramaddr = '0; m_first = '0; m_last = '0;
        m_busy = 1'b0; m_done = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int ai = int'(a);
        if (ai == 0) begin
            m_done = 1'b0; m_irq = 1'b0;
        end else if (ai == 1) begin
            if (d[0] && !m_busy) begin m_busy = 1'b1; m_irq = 1'b0; m_starts++; end
        end else if (!m_busy) begin
            if (ai >= 2 && ai <= 9) m_cent[ai-2] = d;
            else if (ai == 10)      m_ramaddr = d[AW-1:0];
            else if (ai == 11)      m_ram[int'(m_ramaddr)] = d;
            else if (ai == 12)      m_first = d[AW-1:0];
            else if (ai == 13)      m_last = d[AW-1:0];
        end
    endtask

    task automatic model_done();
        m_busy = 1'b0; m_done = 1'b1; m_irq = 1'b1;
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] r = '0;
        int ai = int'(a);
        if (ai == 0) begin r[0] = m_busy; r[1] = m_done; end
        else if (ai >= 2 && ai <= 9) r = m_cent[ai-2];
        else if (ai == 10) r = DW'(m_ramaddr);
        else if (ai == 11) r = (m_busy || !m_ram.exists(int'(m_ramaddr))) ? '0 : m_ram[int'(m_ramaddr)];
        else if (ai == 12) r = DW'(m_first);
        else if (ai == 13) r = DW'(m_last);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand91();
        logic [95:0] t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Values captured in the completing cycle of the latest transfer
    logic [DW-1:0] c_prdata;
    int            c_waits;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [RW-1:0] c_wlo, c_whi;

    // One APB transfer with optional core events injected into the access cycle
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic inj_done, input logic inj_cw,
                            input logic [CIW-1:0] cw_idx, input logic [DW-1:0] cw_data);
        bit got = 0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1; core_done = inj_done; core_cent_we = inj_cw;
        core_cent_idx = cw_idx; core_cent_data = cw_data;
        c_waits = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (pready === 1'b1) begin
                got = 1; c_prdata = prdata; c_we = ram_we; c_addr = ram_addr;
                c_wlo = ram_wdata_lo; c_whi = ram_wdata_hi;
                break;
            end
            c_waits++;
            @(negedge clk);
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; core_done = 1'b0; core_cent_we = 1'b0;
        n_checks++; if (!got) $display("[TB] FAIL pready_timeout addr=%0d: pready=0, required 1", a); else n_pass++;
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        apb_xfer(1'b1, a, d, 1'b0, 1'b0, '0, '0);
        model_write(a, d);
    endtask

    task automatic apb_read(input logic [AW-1:0] a);
        apb_xfer(1'b0, a, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pulse_done();
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
        model_done();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        core_done = 1'b0; core_cent_we = 1'b0; core_cent_idx = '0; core_cent_data = '0;
        model_reset(); m_starts = 0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (prdata !== '0) $display("[TB] FAIL rst_prdata: got %h want 0", prdata); else n_pass++;
        n_checks++; if (pready !== 1'b0) $display("[TB] FAIL rst_pready: got %b want 0", pready); else n_pass++;
        n_checks++; if (interupt !== 1'b0) $display("[TB] FAIL rst_interupt: got %b want 0", interupt); else n_pass++;
        n_checks++; if (core_start !== 1'b0) $display("[TB] FAIL rst_core_start: got %b want 0", core_start); else n_pass++;
        n_checks++; if (core_busy_o !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", core_busy_o); else n_pass++;
        n_checks++; if (cent_flat !== '0) $display("[TB] FAIL rst_cent_flat: got nonzero want 0"); else n_pass++;
        n_checks++; if (first_addr !== '0) $display("[TB] FAIL rst_first: got %0d want 0", first_addr); else n_pass++;
        n_checks++; if (last_addr !== '0) $display("[TB] FAIL rst_last: got %0d want 0", last_addr); else n_pass++;
        n_checks++; if (ram_addr !== '0) $display("[TB] FAIL rst_ram_addr: got %0d want 0", ram_addr); else n_pass++;
        n_checks++; if (ram_we !== 1'b0 || ram_re !== 1'b0) $display("[TB] FAIL rst_ram_strobes: got we=%b re=%b want 0", ram_we, ram_re); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        apb_read(0);
        n_checks++; if (c_prdata !== '0) $display("[TB] FAIL rst_status: got %h want 0", c_prdata); else n_pass++;
    endtask

    task automatic test_centroid();
        logic [DW-1:0] exp;
        apb_write(4, 91'h5A);
        n_checks++; if (cent_flat[272:182] !== 91'h5A) $display("[TB] FAIL cent3_flat: got %h want 5a", cent_flat[272:182]); else n_pass++;
        apb_read(4);
        n_checks++; if (c_waits != 0) $display("[TB] FAIL cent3_waits: got %0d want 0", c_waits); else n_pass++;
        n_checks++; if (c_prdata !== 91'h5A) $display("[TB] FAIL cent3_read: got %h want 5a", c_prdata); else n_pass++;
        repeat (16) apb_write(AW'($urandom_range(2, 9)), rand91());
        for (int i = 0; i < CN; i++) begin
            exp = model_read(AW'(i + 2));
            apb_read(AW'(i + 2));
            n_checks++; if (c_prdata !== exp) $display("[TB] FAIL cent_read[%0d]: got %h want %h", i, c_prdata, exp); else n_pass++;
            n_checks++; if (cent_flat[i*DW +: DW] !== exp) $display("[TB] FAIL cent_flat[%0d]: got %h want %h", i, cent_flat[i*DW +: DW], exp); else n_pass++;
        end
    endtask

    task automatic test_ram_window();
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
        logic [AW-1:0] addrs [$];
        int w0, r0;
        apb_write(10, 91'd9);
        d = {65'd0, 13'd7, 13'd0};
        w0 = we_count;
        apb_write(11, d);
        n_checks++; if (c_we !== 1'b1 || c_addr !== 9'd9) $display("[TB] FAIL ramwr_strobe: got we=%b addr=%0d want we=1 addr=9", c_we, c_addr); else n_pass++;
        n_checks++; if (c_wlo !== 50'hE000 || c_whi !== '0) $display("[TB] FAIL ramwr_data: got lo=%h hi=%h want lo=e000 hi=0", c_wlo, c_whi); else n_pass++;
        n_checks++; if (we_count - w0 != 1) $display("[TB] FAIL ramwr_pulse: got %0d cycles want 1", we_count - w0); else n_pass++;
        r0 = re_count;
        apb_read(11);
        n_checks++; if (c_waits != 1) $display("[TB] FAIL ramrd_waits: got %0d want 1", c_waits); else n_pass++;
        n_checks++; if (c_prdata !== 91'hE000) $display("[TB] FAIL ramrd_data: got %h want e000", c_prdata); else n_pass++;
        n_checks++; if (re_count - r0 != 1) $display("[TB] FAIL ramrd_pulse: got %0d cycles want 1", re_count - r0); else n_pass++;
        repeat (6) begin
            logic [AW-1:0] a = AW'($urandom_range(0, 511));
            d = rand91();
            addrs.push_back(a);
            apb_write(10, DW'(a));
            apb_write(11, d);
            n_checks++; if (c_wlo !== d[RW-1:0] || c_whi !== {9'd0, d[DW-1:RW]}) $display("[TB] FAIL ramwr_split: got lo=%h hi=%h want lo=%h hi=%h", c_wlo, c_whi, d[RW-1:0], {9'd0, d[DW-1:RW]}); else n_pass++;
        end
        foreach (addrs[k]) begin
            apb_write(10, {82'd0, addrs[k]});
            apb_read(10);
            n_checks++; if (c_prdata !== DW'(addrs[k])) $display("[TB] FAIL ramaddr_read: got %h want %h", c_prdata, addrs[k]); else n_pass++;
            exp = model_read(11);
            apb_read(11);
            n_checks++; if (c_prdata !== exp) $display("[TB] FAIL ramrd_rand[%0d]: got %h want %h", addrs[k], c_prdata, exp); else n_pass++;
        end
    endtask

    task automatic test_go_busy();
        int s0, ms0, w0, r0;
        logic [DW-1:0] exp;
        apb_write(12, 91'd1);
        apb_write(13, 91'd10);
        n_checks++; if (first_addr !== m_first || last_addr !== m_last) $display("[TB] FAIL first_last: got %0d/%0d want %0d/%0d", first_addr, last_addr, m_first, m_last); else n_pass++;
        s0 = start_count; ms0 = m_starts;
        apb_write(1, 91'd1);
        n_checks++; if (core_start !== 1'b1) $display("[TB] FAIL start_pulse_hi: got %b want 1", core_start); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (core_start !== 1'b0) $display("[TB] FAIL start_pulse_lo: got %b want 0", core_start); else n_pass++;
        n_checks++; if (start_count - s0 != m_starts - ms0) $display("[TB] FAIL start_count: got %0d want %0d", start_count - s0, m_starts - ms0); else n_pass++;
        n_checks++; if (core_busy_o !== m_busy) $display("[TB] FAIL busy_out: got %b want %b", core_busy_o, m_busy); else n_pass++;
        exp = model_read(0);
        apb_read(0);
        n_checks++; if (c_prdata !== exp) $display("[TB] FAIL status_busy: got %h want %h", c_prdata, exp); else n_pass++;
        apb_write(5, rand91());
        exp = model_read(5);
        apb_read(5);
        n_checks++; if (c_prdata !== exp) $display("[TB] FAIL cent_locked: got %h want %h", c_prdata, exp); else n_pass++;
        w0 = we_count;
        apb_write(11, rand91());
        n_checks++; if (we_count != w0) $display("[TB] FAIL busy_ram_we: got %0d pulses want 0", we_count - w0); else n_pass++;
        r0 = re_count;
        apb_read(11);
        n_checks++; if (c_waits != 0 || c_prdata !== '0) $display("[TB] FAIL busy_ram_rd: got waits=%0d data=%h want 0/0", c_waits, c_prdata); else n_pass++;
        n_checks++; if (re_count != r0) $display("[TB] FAIL busy_ram_re: got %0d pulses want 0", re_count - r0); else n_pass++;
        apb_write(12, 91'd77);
        n_checks++; if (first_addr !== m_first) $display("[TB] FAIL first_locked: got %0d want %0d", first_addr, m_first); else n_pass++;
        s0 = start_count; ms0 = m_starts;
        apb_write(1, 91'd1);
        repeat (2) @(negedge clk);
        n_checks++; if (start_count - s0 != m_starts - ms0) $display("[TB] FAIL go_while_busy: got %0d pulses want %0d", start_count - s0, m_starts - ms0); else n_pass++;
    endtask

    task automatic test_done_irq();
        logic [DW-1:0] exp;
        logic [DW-1:0] d;
        pulse_done();
        n_checks++; if (interupt !== m_irq) $display("[TB] FAIL done_irq: got %b want %b", interupt, m_irq); else n_pass++;
        n_checks++; if (core_busy_o !== m_busy) $display("[TB] FAIL done_busy: got %b want %b", core_busy_o, m_busy); else n_pass++;
        exp = model_read(0);
        apb_read(0);
        n_checks++; if (c_prdata !== exp) $display("[TB] FAIL status_done: got %h want %h", c_prdata, exp); else n_pass++;
        apb_write(0, rand91());
        n_checks++; if (interupt !== m_irq) $display("[TB] FAIL irq_clear: got %b want %b", interupt, m_irq); else n_pass++;
        exp = model_read(0);
        apb_read(0);
        n_checks++; if (c_prdata !== exp) $display("[TB] FAIL status_clear: got %h want %h", c_prdata, exp); else n_pass++;
        d = rand91();
        apb_xfer(1'b1, 0, d, 1'b1, 1'b0, '0, '0);
        model_write(0, d);
        model_done();
        n_checks++; if (interupt !== m_irq) $display("[TB] FAIL irq_set_wins: got %b want %b", interupt, m_irq); else n_pass++;
        exp = model_read(0);
        apb_read(0);
        n_checks++; if (c_prdata !== exp) $display("[TB] FAIL status_set_wins: got %h want %h", c_prdata, exp); else n_pass++;
    endtask

    task automatic test_cent_writeback();
        logic [DW-1:0] exp;
        apb_xfer(1'b1, 9, 91'h3, 1'b0, 1'b1, 3'd7, 91'h8);
        model_write(9, 91'h3);
        m_cent[7] = 91'h8;
        n_checks++; if (cent_flat[7*DW +: DW] !== m_cent[7]) $display("[TB] FAIL cw_priority: got %h want %h", cent_flat[7*DW +: DW], m_cent[7]); else n_pass++;
        repeat (6) begin
            logic [CIW-1:0] idx = CIW'($urandom_range(0, 7));
            logic [DW-1:0]  d = rand91();
            @(negedge clk); core_cent_we = 1'b1; core_cent_idx = idx; core_cent_data = d;
            @(negedge clk); core_cent_we = 1'b0;
            m_cent[idx] = d;
            exp = model_read(AW'(idx) + 9'd2);
            apb_read(AW'(idx) + 9'd2);
            n_checks++; if (c_prdata !== exp) $display("[TB] FAIL cw_read[%0d]: got %h want %h", idx, c_prdata, exp); else n_pass++;
        end
    endtask

    task automatic test_unmapped();
        apb_write(20, rand91());
        apb_read(20);
        n_checks++; if (c_waits != 0 || c_prdata !== '0) $display("[TB] FAIL unmapped20: got waits=%0d data=%h want 0/0", c_waits, c_prdata); else n_pass++;
        apb_read(14);
        n_checks++; if (c_prdata !== '0) $display("[TB] FAIL unmapped14: got %h want 0", c_prdata); else n_pass++;
        apb_read(511);
        n_checks++; if (c_prdata !== '0) $display("[TB] FAIL unmapped511: got %h want 0", c_prdata); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d = rand91();
        apb_write(2, rand91());
        apb_write(12, 91'd3);
        apb_write(10, 91'd5);
        apb_write(11, d);
        pulse_done();
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 9'd11;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (pready !== 1'b1 || prdata !== d) $display("[TB] FAIL wait_before_rst: got rdy=%b data=%h want 1/%h", pready, prdata, d); else n_pass++;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (prdata !== '0 || pready !== 1'b0) $display("[TB] FAIL midrst_bus: got data=%h rdy=%b want 0/0", prdata, pready); else n_pass++;
        n_checks++; if (interupt !== 1'b0 || core_busy_o !== 1'b0) $display("[TB] FAIL midrst_ctrl: got irq=%b busy=%b want 0/0", interupt, core_busy_o); else n_pass++;
        n_checks++; if (cent_flat !== '0 || ram_addr !== '0 || first_addr !== '0 || last_addr !== '0) $display("[TB] FAIL midrst_regs: got nonzero want 0"); else n_pass++;
        @(negedge clk); psel = 1'b0; penable = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        apb_read(20);
        n_checks++; if (c_prdata !== '0) $display("[TB] FAIL post_rst_unmapped: got %h want 0", c_prdata); else n_pass++;
        apb_read(2);
        n_checks++; if (c_prdata !== m_cent[0]) $display("[TB] FAIL post_rst_cent: got %h want %h", c_prdata, m_cent[0]); else n_pass++;
        apb_read(0);
        n_checks++; if (c_prdata !== model_read(0)) $display("[TB] FAIL post_rst_status: got %h want 0", c_prdata); else n_pass++;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_centroid();
        test_ram_window();
        test_go_busy();
        test_done_irq();
        test_cent_writeback();
        test_unmapped();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
